// File: rtl/nibbler_mem_pkg.sv
// Shared definitions for the Nibbler nibble-RAM access path: bus widths,
// sequencer state encoding and the wrapping address increment.
package nibbler_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_WR_HOLD = 3'd3;
  localparam logic [2:0] ST_RD      = 3'd4;
  localparam logic [2:0] ST_RD_CAP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SETUP   = ST_SETUP,
    WR      = ST_WR,
    WR_HOLD = ST_WR_HOLD,
    RD      = ST_RD,
    RD_CAP  = ST_RD_CAP
  } state_t;

  // Burst address step; the natural ADDR_W-bit overflow gives the 4095 -> 0 wrap.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake between the Nibbler datapath (master) and the
// RAM access sequencer (slave).
interface ram_access_ctrl_if;
  import nibbler_mem_pkg::*;

  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              done;

  modport master (
    output req, rw, addr_in, wdata, len,
    input  busy, rdata, rvalid, done
  );

  modport slave (
    input  req, rw, addr_in, wdata, len,
    output busy, rdata, rvalid, done
  );

endinterface

// File: rtl/ram_bus_tri.sv
// Tristate driver for the bidirectional RAM data bus; q always reflects the pad.
module ram_bus_tri
  import nibbler_mem_pkg::*;
(
  input  logic              oe,
  input  logic [DATA_W-1:0] d,
  inout  wire  [DATA_W-1:0] pad,
  output logic [DATA_W-1:0] q
);

  assign pad = oe ? d : 'z;
  assign q   = pad;

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer between the Nibbler datapath and the 4096x4 nibble RAM. Turns a
// one-cycle request into SETUP/strobe/hold RAM cycles so the address is stable
// around every write strobe, and runs auto-incrementing read bursts. Every RAM
// pin decodes from the registered state only.
module ram_access_ctrl
  import nibbler_mem_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  ram_access_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0]  address,
  output logic               csRam,
  output logic               weRam,
  inout  wire  [DATA_W-1:0]  salida
);

  state_t            state;
  state_t            state_nx;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              done_rd_q;
  logic              bus_oe;
  logic              busy_c;
  logic              done_wr_c;
  logic [DATA_W-1:0] bus_q;

  // State register; reset abandons whatever operation is in flight.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and RAM-side control decode from the registered state.
  always_comb begin
    state_nx  = state;
    csRam     = 1'b0;
    weRam     = 1'b0;
    bus_oe    = 1'b0;
    busy_c    = 1'b1;
    done_wr_c = 1'b0;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.req) state_nx = SETUP;
      end
      SETUP:   state_nx = rw_q ? WR : RD;
      WR: begin
        csRam    = 1'b1;
        weRam    = 1'b1;
        bus_oe   = 1'b1;
        state_nx = WR_HOLD;
      end
      WR_HOLD: begin
        // Keep driving data one cycle past the strobe for RAM hold time.
        bus_oe    = 1'b1;
        done_wr_c = 1'b1;
        state_nx  = IDLE;
      end
      RD: begin
        csRam    = 1'b1;
        state_nx = RD_CAP;
      end
      RD_CAP: begin
        csRam    = 1'b1;
        state_nx = (cnt == '0) ? IDLE : SETUP;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, burst counter/address step, and read capture with its pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      address   <= '0;
      rw_q      <= 1'b0;
      cnt       <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      done_rd_q <= 1'b0;
    end else begin
      rvalid_q  <= 1'b0;
      done_rd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            address <= bus.addr_in;
            rw_q    <= bus.rw;
            wdata_q <= bus.wdata;
            cnt     <= bus.rw ? '0 : bus.len;
          end
        end
        RD_CAP: begin
          rdata_q   <= bus_q;
          rvalid_q  <= 1'b1;
          done_rd_q <= (cnt == '0);
          if (cnt != '0) begin
            address <= next_addr(address);
            cnt     <= cnt - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  ram_bus_tri u_tri (
    .oe  (bus_oe),
    .d   (wdata_q),
    .pad (salida),
    .q   (bus_q)
  );

  assign bus.busy   = busy_c;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.done   = done_wr_c | done_rd_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl attached to a behavioural 4096x4 RAM.
module tb_ram_access_ctrl;
  import nibbler_mem_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              csRam;
  logic              weRam;
  wire  [DATA_W-1:0] salida;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_access_ctrl_if bus();

  ram_access_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .address (address),
    .csRam   (csRam),
    .weRam   (weRam),
    .salida  (salida)
  );

  // Behavioural RAM with a bench-side preload port.
  logic [DATA_W-1:0] mem [0:4095];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic              ram_oe;
  logic [DATA_W-1:0] ram_q;

  assign ram_oe = csRam & ~weRam;
  assign ram_q  = mem[address];
  assign salida = ram_oe ? ram_q : 'z;

  always @(posedge clock) begin
    if (pl_en)               mem[pl_addr] <= pl_data;
    else if (csRam && weRam) mem[address] <= salida;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every-cycle monitor of the write-strobe and read-bus rules.
  logic              prev_we   = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  always @(negedge clock) begin
    if (weRam) begin
      check("mon_we_with_cs", {31'd0, csRam}, 32'd1);
      check("mon_we_single", {31'd0, prev_we}, 32'd0);
      check("mon_we_addr_setup", {20'd0, address}, {20'd0, prev_addr});
    end
    if (prev_we) check("mon_we_addr_hold", {20'd0, address}, {20'd0, prev_addr});
    if (csRam && !weRam) check("mon_read_bus", {28'd0, salida}, {28'd0, mem[address]});
    prev_we   = weRam;
    prev_addr = address;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  logic [DATA_W-1:0] exp_beats [16];

  // Issues one request in the current (IDLE) cycle and checks every following
  // cycle against the expected sequence; returns in an IDLE cycle.
  task automatic run_op(input logic rw_i, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [LEN_W-1:0] ln,
                        input string nm);
    int nb, last, b;
    logic [ADDR_W-1:0] ea;
    logic e_busy, e_cs, e_we, e_done, e_rv;
    bus.req = 1'b1; bus.rw = rw_i; bus.addr_in = a; bus.wdata = wd; bus.len = ln;
    step();
    bus.req = 1'b0;
    nb   = rw_i ? 0 : int'(ln);
    last = rw_i ? 4 : 3 * nb + 4;
    for (int k = 1; k <= last; k++) begin
      b = (k - 1) / 3;
      if (b > nb) b = nb;
      ea = a + ADDR_W'(b);
      if (rw_i) begin
        e_busy = (k <= 3); e_cs = (k == 2); e_we = (k == 2);
        e_done = (k == 3); e_rv = 1'b0;
      end else begin
        e_busy = (k <= 3 * nb + 3); e_cs = ((k % 3) != 1); e_we = 1'b0;
        e_rv = (k >= 4) && ((k % 3) == 1); e_done = (k == last);
      end
      check($sformatf("%s busy c%0d", nm, k), {31'd0, bus.busy}, {31'd0, e_busy});
      check($sformatf("%s cs c%0d", nm, k), {31'd0, csRam}, {31'd0, e_cs});
      check($sformatf("%s we c%0d", nm, k), {31'd0, weRam}, {31'd0, e_we});
      check($sformatf("%s done c%0d", nm, k), {31'd0, bus.done}, {31'd0, e_done});
      check($sformatf("%s rvalid c%0d", nm, k), {31'd0, bus.rvalid}, {31'd0, e_rv});
      check($sformatf("%s address c%0d", nm, k), {20'd0, address}, {20'd0, ea});
      if (e_rv)
        check($sformatf("%s rdata beat%0d", nm, (k - 4) / 3), {28'd0, bus.rdata},
              {28'd0, exp_beats[(k - 4) / 3]});
      if (k < last) step();
    end
    if (rw_i) check($sformatf("%s mem", nm), {28'd0, mem[a]}, {28'd0, wd});
  endtask

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  initial begin
    vec[0]  = '{1'b1, 12'h123, 4'hA, 4'h0};
    vec[1]  = '{1'b0, 12'h123, 4'h0, 4'hA};
    vec[2]  = '{1'b1, 12'h000, 4'hF, 4'h0};
    vec[3]  = '{1'b1, 12'hFFF, 4'h0, 4'h0};
    vec[4]  = '{1'b0, 12'h000, 4'h0, 4'hF};
    vec[5]  = '{1'b0, 12'hFFF, 4'h0, 4'h0};
    vec[6]  = '{1'b1, 12'h555, 4'h5, 4'h0};
    vec[7]  = '{1'b1, 12'hAAA, 4'hA, 4'h0};
    vec[8]  = '{1'b0, 12'h555, 4'h0, 4'h5};
    vec[9]  = '{1'b0, 12'hAAA, 4'h0, 4'hA};
    vec[10] = '{1'b1, 12'h123, 4'h3, 4'h0};
    vec[11] = '{1'b0, 12'h123, 4'h0, 4'h3};

    reset = 1'b1;
    bus.req = 1'b0; bus.rw = 1'b0; bus.addr_in = '0; bus.wdata = '0; bus.len = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) step();
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset cs", {31'd0, csRam}, 32'd0);
    check("reset we", {31'd0, weRam}, 32'd0);
    check("reset rdata", {28'd0, bus.rdata}, 32'd0);
    check("reset address", {20'd0, address}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      exp_beats[0] = vec[i].exp;
      run_op(vec[i].rw, vec[i].addr, vec[i].wdata, '0, $sformatf("vec%0d", i));
    end

    // Four-beat burst.
    preload(12'h010, 4'h1); preload(12'h011, 4'h2);
    preload(12'h012, 4'h3); preload(12'h013, 4'h4);
    exp_beats[0] = 4'h1; exp_beats[1] = 4'h2; exp_beats[2] = 4'h3; exp_beats[3] = 4'h4;
    run_op(1'b0, 12'h010, 4'h0, 4'd3, "burst");

    // Burst across the top of memory.
    preload(12'hFFF, 4'h5); preload(12'h000, 4'h6);
    exp_beats[0] = 4'h5; exp_beats[1] = 4'h6;
    run_op(1'b0, 12'hFFF, 4'h0, 4'd1, "wrap");

    // A request during a write is dropped, not queued.
    preload(12'h200, 4'h3);
    bus.req = 1'b1; bus.rw = 1'b1; bus.addr_in = 12'h100; bus.wdata = 4'h1;
    step();                                   // SETUP
    bus.req = 1'b0;
    step();                                   // WR
    bus.req = 1'b1; bus.addr_in = 12'h200; bus.wdata = 4'h7;
    step();                                   // WR_HOLD
    bus.req = 1'b0;
    step();                                   // IDLE
    check("ignore busy idle", {31'd0, bus.busy}, 32'd0);
    step();
    check("ignore not queued", {31'd0, bus.busy}, 32'd0);
    check("ignore mem 0x100", {28'd0, mem[12'h100]}, 32'd1);
    check("ignore mem 0x200", {28'd0, mem[12'h200]}, 32'd3);

    // req held high: next op starts in the first IDLE cycle, including the
    // IDLE cycle that carries a read done pulse.
    bus.req = 1'b1; bus.rw = 1'b1; bus.addr_in = 12'h300; bus.wdata = 4'h9;
    step();                                   // c1 SETUP
    bus.rw = 1'b0; bus.addr_in = 12'h010; bus.len = 4'd0;
    step();                                   // c2 WR
    step();                                   // c3 WR_HOLD
    check("held wr done", {31'd0, bus.done}, 32'd1);
    step();                                   // c4 IDLE, read accepted
    check("held idle busy", {31'd0, bus.busy}, 32'd0);
    step();                                   // c5
    check("held read accepted", {31'd0, bus.busy}, 32'd1);
    bus.rw = 1'b1; bus.addr_in = 12'h400; bus.wdata = 4'hC;
    step(); step(); step();                   // c8 IDLE with rvalid/done
    check("held rd rvalid", {31'd0, bus.rvalid}, 32'd1);
    check("held rd done", {31'd0, bus.done}, 32'd1);
    check("held rd rdata", {28'd0, bus.rdata}, 32'd1);
    step();                                   // c9
    bus.req = 1'b0;
    check("held wr2 accepted", {31'd0, bus.busy}, 32'd1);
    step();                                   // c10
    check("held wr2 we", {31'd0, weRam}, 32'd1);
    check("held wr2 address", {20'd0, address}, 32'h400);
    step(); step();                           // c12
    check("held mem 0x300", {28'd0, mem[12'h300]}, 32'h9);
    check("held mem 0x400", {28'd0, mem[12'h400]}, 32'hC);

    // Reset in RD_CAP of a burst.
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr_in = 12'h010; bus.len = 4'd3;
    step();
    bus.req = 1'b0;
    step(); step();                           // RD_CAP
    check("rst pre cs", {31'd0, csRam}, 32'd1);
    reset = 1'b1;
    step();
    check("rst cs", {31'd0, csRam}, 32'd0);
    check("rst we", {31'd0, weRam}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst address", {20'd0, address}, 32'd0);
    check("rst rdata", {28'd0, bus.rdata}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("post rst rvalid c%0d", i), {31'd0, bus.rvalid}, 32'd0);
      check($sformatf("post rst done c%0d", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("post rst busy c%0d", i), {31'd0, bus.busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
